// File: rtl/adder_muldiv_seq.sv
// Iterative 32-bit unsigned MUL/MULHU/DIVU/REMU sequencer driving one external adder.
// Optional early-out for zero operands when MULDIV_EARLY_OUT_EN is defined.
module adder_muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] add_a,
  output logic [XLEN-1:0] add_b,
  output logic            add_c0,
  input  logic [XLEN-1:0] add_s,
  input  logic            add_c32
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_t            state;
  state_t            state_nxt;
  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;
  logic [XLEN-1:0]   mcand;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        op_q;

  logic              accept;
  logic              div_zero;
  logic              quick;
  logic [XLEN-1:0]   quick_res;
  logic [XLEN-1:0]   div_rem;
  logic              div_ok;
  logic [XLEN-1:0]   hi_step;
  logic [XLEN-1:0]   lo_step;
  logic [XLEN-1:0]   result_nxt;

  // op[1] selects divide, op[0] selects the hi half (MULHU/REMU).
  assign accept   = (state == S_IDLE) && start && !kill;
  assign div_zero = op[1] && (b == '0);

`ifdef MULDIV_EARLY_OUT_EN
  assign quick = div_zero || (a == '0) || (!op[1] && (b == '0));
`else
  assign quick = div_zero;
`endif

  always_comb begin
    quick_res = '0;
    if (div_zero) begin
      quick_res = op[0] ? a : '1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = quick ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (kill) begin
          state_nxt = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM: outputs, including the adder drive
  assign div_rem = {hi[XLEN-2:0], lo[XLEN-1]};

  always_comb begin
    busy   = (state != S_IDLE);
    done   = (state == S_DONE);
    add_a  = '0;
    add_b  = '0;
    add_c0 = 1'b0;
    if (state == S_RUN) begin
      if (op_q[1]) begin
        add_a  = div_rem;
        add_b  = ~mcand;
        add_c0 = 1'b1;
      end else begin
        add_a  = hi;
        add_b  = lo[0] ? mcand : '0;
      end
    end
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    div_ok = hi[XLEN-1] | add_c32;
    if (op_q[1]) begin
      hi_step = div_ok ? add_s : div_rem;
      lo_step = {lo[XLEN-2:0], div_ok};
    end else begin
      hi_step = {add_c32, add_s[XLEN-1:1]};
      lo_step = {add_s[0], lo[XLEN-1:1]};
    end
  end

  always_comb begin
    if (state == S_RUN) begin
      result_nxt = op_q[0] ? hi_step : lo_step;
    end else begin
      result_nxt = quick_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      cnt   <= '0;
      op_q  <= 2'b00;
    end else if (accept) begin
      hi    <= '0;
      lo    <= a;
      mcand <= b;
      cnt   <= '0;
      op_q  <= op;
    end else if ((state == S_RUN) && !kill) begin
      hi    <= hi_step;
      lo    <= lo_step;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  // Result only moves on entry to DONE, so a kill leaves the previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else if (state_nxt == S_DONE) begin
      result <= result_nxt;
    end
  end

endmodule
